// File: rtl/ifu_fetch_fsm.sv
// Multi-cycle instruction fetch stage: one instruction in flight.
// Issues an address on the AR channel, takes the word on the R channel,
// presents {pc, inst, fetch_fault} to the IDU, then waits for dnpc.
module ifu_fetch_fsm #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dnpc,
  input  logic             dnpc_valid,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             fetch_fault,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_RESP     = 2'd1,
    S_OUT      = 2'd2,
    S_WAIT_NPC = 2'd3
  } state_t;

  state_t state;

  logic misaligned;

  // A misaligned PC never reaches memory; it is reported as a fault instead.
  always_comb begin
    misaligned = (pc[1:0] != 2'b00);
    araddr     = pc;
    arvalid    = (state == S_REQ) && !misaligned;
    rready     = (state == S_RESP);
    inst_valid = (state == S_OUT);
    busy       = (state != S_WAIT_NPC);
  end

  // Fetch sequencing and the registered {pc, inst, fetch_fault} payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= WIDTH'(RESET_PC);
      inst        <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            fetch_fault <= 1'b1;
            inst        <= '0;
            state       <= S_OUT;
          end else if (arready) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rvalid) begin
            inst        <= rdata;
            fetch_fault <= (rresp != 2'b00);
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          // dnpc coinciding with the IDU handshake skips S_WAIT_NPC.
          if (inst_ready) begin
            if (dnpc_valid) begin
              pc          <= dnpc;
              fetch_fault <= 1'b0;
              state       <= S_REQ;
            end else begin
              state <= S_WAIT_NPC;
            end
          end
        end
        S_WAIT_NPC: begin
          if (dnpc_valid) begin
            pc          <= dnpc;
            fetch_fault <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_fsm.sv
// Directed bench for ifu_fetch_fsm: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed per vector.
`timescale 1ns/1ps
module tb_ifu_fetch_fsm;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_fault;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned ar_hs  = 0;

  ifu_fetch_fsm #(.RESET_PC(RST_PC), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dnpc       (dnpc),
    .dnpc_valid (dnpc_valid),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_fault(fetch_fault),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-channel handshake counter.
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full fetch starting at a falling edge with the DUT in S_REQ.
  task automatic fetch(input logic [31:0] addr, input int unsigned ar_wait,
                       input int unsigned r_wait, input logic [31:0] word,
                       input logic [1:0] resp, input int unsigned out_wait,
                       input logic spur_resp, input logic spur_out);
    int unsigned hs0;
    hs0 = ar_hs;
    check("req_arvalid", 32'(arvalid), 32'd1);
    check("req_araddr", araddr, addr);
    check("req_busy", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      check("arwait_arvalid", 32'(arvalid), 32'd1);
      check("arwait_araddr", araddr, addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("resp_rready", 32'(rready), 32'd1);
    check("resp_arvalid", 32'(arvalid), 32'd0);
    check("resp_inst_valid", 32'(inst_valid), 32'd0);
    for (int unsigned i = 0; i < r_wait; i++) begin
      if (spur_resp && i == 0) begin
        dnpc = 32'h1234_5678;
        dnpc_valid = 1'b1;
      end
      @(negedge clk);
      dnpc_valid = 1'b0;
      check("rwait_rready", 32'(rready), 32'd1);
    end
    rvalid = 1'b1;
    rdata  = word;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    rresp  = 2'b00;
    check("out_inst_valid", 32'(inst_valid), 32'd1);
    check("out_pc", pc, addr);
    check("out_inst", inst, word);
    check("out_fault", 32'(fetch_fault), 32'(resp != 2'b00));
    check("ar_handshakes", ar_hs - hs0, 32'd1);
    for (int unsigned i = 0; i < out_wait; i++) begin
      if (spur_out && i == 1) begin
        dnpc = 32'h4444_4444;
        dnpc_valid = 1'b1;
      end
      @(negedge clk);
      dnpc_valid = 1'b0;
      check("outwait_inst_valid", 32'(inst_valid), 32'd1);
      check("outwait_pc", pc, addr);
      check("outwait_inst", inst, word);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("wait_inst_valid", 32'(inst_valid), 32'd0);
    check("wait_busy", 32'(busy), 32'd0);
    check("wait_arvalid", 32'(arvalid), 32'd0);
  endtask

  task automatic send_dnpc(input logic [31:0] v);
    dnpc = v;
    dnpc_valid = 1'b1;
    @(negedge clk);
    dnpc_valid = 1'b0;
    check("npc_pc", pc, v);
  endtask

  task automatic check_reset_outputs();
    check("rst_arvalid", 32'(arvalid), 32'd1);
    check("rst_araddr", araddr, RST_PC);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    dnpc = '0;
    dnpc_valid = 1'b0;
    arready = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    rvalid = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Zero-wait fetch at reset PC.
    fetch(RST_PC, 0, 0, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0);

    // Sequential PC, arready and rvalid back-pressure.
    send_dnpc(32'h8000_0004);
    fetch(32'h8000_0004, 5, 3, 32'h0051_0113, 2'b00, 4, 1'b0, 1'b1);

    // Misaligned PC: fault without a memory request.
    send_dnpc(32'h8000_0006);
    check("mis_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    check("mis_inst_valid", 32'(inst_valid), 32'd1);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_pc", pc, 32'h8000_0006);
    check("mis_inst", inst, 32'd0);
    // dnpc in the same cycle as inst_ready goes straight to S_REQ.
    inst_ready = 1'b1;
    dnpc = 32'h8000_0008;
    dnpc_valid = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    dnpc_valid = 1'b0;
    check("same_cyc_pc", pc, 32'h8000_0008);
    check("same_cyc_fault", 32'(fetch_fault), 32'd0);
    fetch(32'h8000_0008, 0, 0, 32'h00A0_0093, 2'b00, 0, 1'b0, 1'b0);

    // Access error with a spurious dnpc during S_RESP.
    send_dnpc(32'h8000_000C);
    fetch(32'h8000_000C, 1, 2, 32'hCAFE_F00D, 2'b10, 1, 1'b1, 1'b0);

    // Reset pulsed while in S_RESP.
    send_dnpc(32'h8000_0010);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("pre_rst_rready", 32'(rready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    fetch(RST_PC, 0, 1, 32'h0000_0513, 2'b00, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
